// File: rtl/xbar_bridge_pkg.sv
// rtl/xbar_bridge_pkg.sv - shared widths and payload sizing for the bridge request path
package xbar_bridge_pkg;

  localparam int unsigned XBAR_ADDR_WIDTH_DEF = 32;
  localparam int unsigned XBAR_ID_WIDTH_DEF   = 20;
  localparam int unsigned XBAR_DATA_WIDTH_DEF = 32;
  localparam int unsigned XBAR_AUX_WIDTH_DEF  = 6;
  localparam int unsigned XBAR_DEPTH_DEF      = 4;
  localparam int unsigned XBAR_MAX_OUT_DEF    = 8;

  // Payload is packed {wen, ID, aux, be, add, wdata}.
  function automatic int unsigned bridge_payload_width(
    input int unsigned addr_w,
    input int unsigned id_w,
    input int unsigned data_w,
    input int unsigned be_w,
    input int unsigned aux_w
  );
    return addr_w + 1 + data_w + be_w + id_w + aux_w;
  endfunction

endpackage

// File: rtl/xbar_bridge_req_fifo.sv
// rtl/xbar_bridge_req_fifo.sv - generic DEPTH x WIDTH FIFO with wrap-bit pointers
module xbar_bridge_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    last_idx;
  logic             do_push, do_pop;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  // When drained, the head slot is stale; show the most recently written entry instead.
  assign last_idx = wr_ptr_q[AW-1:0] - AW'(1);
  assign rdata_o  = empty_o ? mem_q[last_idx] : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/xbar_bridge_req_buffer.sv
// rtl/xbar_bridge_req_buffer.sv - elastic request buffer with outstanding-transaction throttle
// XBAR_BRIDGE_REQ_FALLTHROUGH_EN adds a combinational bypass when the buffer is empty.
module xbar_bridge_req_buffer
  import xbar_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = XBAR_ADDR_WIDTH_DEF,
  parameter int unsigned ID_WIDTH        = XBAR_ID_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = XBAR_DATA_WIDTH_DEF,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned AUX_WIDTH       = XBAR_AUX_WIDTH_DEF,
  parameter int unsigned DEPTH           = XBAR_DEPTH_DEF,
  parameter int unsigned MAX_OUTSTANDING = XBAR_MAX_OUT_DEF,
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  input  logic [AUX_WIDTH-1:0]  data_aux_i,
  output logic                  data_gnt_o,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [ID_WIDTH-1:0]   data_ID_o,
  output logic [AUX_WIDTH-1:0]  data_aux_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  output logic [CW-1:0]         outstanding_o,
  output logic                  busy_o
);

  localparam int unsigned PW = bridge_payload_width(ADDR_WIDTH, ID_WIDTH, DATA_WIDTH,
                                                    BE_WIDTH, AUX_WIDTH);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [PW-1:0] in_pl, head_pl, out_pl;
  logic          full, empty, below_lim, ft;
  logic          push, pop, fifo_push, fifo_pop, rsp_ok;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_pl = {data_wen_i, data_ID_i, data_aux_i, data_be_i, data_add_i, data_wdata_i};

  xbar_bridge_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (in_pl),
    .pop_i   (fifo_pop),
    .rdata_o (head_pl),
    .full_o  (full),
    .empty_o (empty)
  );

  assign below_lim = (cnt_q != MAX_CNT);
  assign data_gnt_o = ~full;

`ifdef XBAR_BRIDGE_REQ_FALLTHROUGH_EN
  assign ft = empty & below_lim;
`else
  assign ft = 1'b0;
`endif

  assign data_req_o = ft ? data_req_i : (~empty & below_lim);
  assign out_pl     = ft ? in_pl : head_pl;
  assign {data_wen_o, data_ID_o, data_aux_o, data_be_o, data_add_o, data_wdata_o} = out_pl;

  assign push = data_req_i & data_gnt_o;
  assign pop  = data_req_o & data_gnt_i;
  // A bypassed request consumed by the target in the same cycle never enters storage.
  assign fifo_push = push & ~(ft & data_gnt_i);
  assign fifo_pop  = pop & ~ft;

  // Responses with nothing in flight are spurious and dropped.
  assign rsp_ok = data_r_valid_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (pop && !rsp_ok)      cnt_d = cnt_q + CW'(1);
    else if (!pop && rsp_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = ~empty | (cnt_q != '0);

endmodule
